// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// =============================================================================
// pattern_scan_ctrl
//   Serializes parallel words MSB-first and counts overlapping matches of a
//   programmable 1..8 bit pattern, raising a sticky interrupt at a threshold.
//   Revision: 1.0
// =============================================================================
module pattern_scan_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [7:0]        cfg_pattern,
   input  logic [3:0]        cfg_len,
   input  logic [CNT_W-1:0]  cfg_thresh,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              bit_valid,
   output logic              bit_out,
   output logic              match,
   output logic [CNT_W-1:0]  match_count,
   output logic              irq,
   input  logic              irq_clr,
   output logic              busy
);
   localparam int               BC_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BC_W-1:0]  LAST_BIT    = BC_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [7:0]       RST_PATTERN = 8'b0000_1101;
   localparam logic [3:0]       RST_LEN     = 4'd4;
   localparam logic [CNT_W-1:0] RST_THRESH  = CNT_W'(1);

   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic              bit_valid_q, bit_valid_d;
   logic              bit_out_q, bit_out_d;
   logic [7:0]        hist_q, hist_d;
   logic [3:0]        fill_q, fill_d;
   logic [7:0]        pat_q, pat_d;
   logic [3:0]        len_q, len_d;
   logic [CNT_W-1:0]  thresh_q, thresh_d;
   logic              match_q, match_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              irq_q, irq_d;

   logic              w_accept;
   logic              w_cfg;
   logic              w_hit;
   logic [7:0]        w_mask;
   logic [3:0]        w_len_clamp;
   logic [CNT_W-1:0]  w_cnt_inc;

   // A bit enters history one edge before it is judged, so bit_valid_q marks
   // exactly one evaluation per emitted bit.
   always_comb begin
      w_accept    = (state_q == IDLE) && in_valid;
      w_cfg       = (state_q == IDLE) && cfg_we && !in_valid;
      w_mask      = 8'((9'd1 << len_q) - 9'd1);
      w_hit       = bit_valid_q && (fill_q >= len_q) && ((hist_q & w_mask) == (pat_q & w_mask));
      w_cnt_inc   = cnt_q + 1'b1;
      if (cfg_len == 4'd0)      w_len_clamp = 4'd1;
      else if (cfg_len > 4'd8)  w_len_clamp = 4'd8;
      else                      w_len_clamp = cfg_len;
   end

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      bit_valid_d = 1'b0;
      bit_out_d   = bit_out_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      pat_d       = pat_q;
      len_d       = len_q;
      thresh_d    = thresh_q;
      match_d     = 1'b0;
      cnt_d       = cnt_q;
      irq_d       = irq_q & ~irq_clr;

      case (state_q)
         IDLE: begin
            if (w_accept) begin
               sr_d      = in_data;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            bit_out_d   = sr_q[DATA_W-1];
            bit_valid_d = 1'b1;
            sr_d        = sr_q << 1;
            bit_cnt_d   = bit_cnt_q + 1'b1;
            hist_d      = {hist_q[6:0], sr_q[DATA_W-1]};
            fill_d      = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (w_hit) begin
         match_d = 1'b1;
         if (cnt_q != CNT_MAX) begin
            cnt_d = w_cnt_inc;
            if ((thresh_q != '0) && (w_cnt_inc == thresh_q)) irq_d = 1'b1;
         end
      end

      // A config write restarts detection, overriding any pending evaluation.
      if (w_cfg) begin
         pat_d    = cfg_pattern;
         len_d    = w_len_clamp;
         thresh_d = cfg_thresh;
         hist_d   = '0;
         fill_d   = '0;
         cnt_d    = '0;
         irq_d    = 1'b0;
         match_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         bit_valid_q <= 1'b0;
         bit_out_q   <= 1'b0;
         hist_q      <= '0;
         fill_q      <= '0;
         pat_q       <= RST_PATTERN;
         len_q       <= RST_LEN;
         thresh_q    <= RST_THRESH;
         match_q     <= 1'b0;
         cnt_q       <= '0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_valid_q <= bit_valid_d;
         bit_out_q   <= bit_out_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         pat_q       <= pat_d;
         len_q       <= len_d;
         thresh_q    <= thresh_d;
         match_q     <= match_d;
         cnt_q       <= cnt_d;
         irq_q       <= irq_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q == SHIFT);
   assign bit_valid   = bit_valid_q;
   assign bit_out     = bit_out_q;
   assign match       = match_q;
   assign match_count = cnt_q;
   assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// =============================================================================
// tb_pattern_scan_ctrl
//   Directed and random stimulus against a bit-level behavioural model.
//   Revision: 1.0
// =============================================================================
module tb_pattern_scan_ctrl;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we, in_valid, irq_clr;
   logic [7:0]       cfg_pattern;
   logic [3:0]       cfg_len;
   logic [CNT_W-1:0] cfg_thresh;
   logic [7:0]       in_data;
   logic             in_ready, bit_valid, bit_out, match, irq, busy;
   logic [CNT_W-1:0] match_count;

   logic             d2_cfg_we, d2_in_valid, d2_irq_clr;
   logic [7:0]       d2_cfg_pattern, d2_in_data;
   logic [3:0]       d2_cfg_len;
   logic [1:0]       d2_cfg_thresh, d2_match_count;
   logic             d2_in_ready, d2_bit_valid, d2_bit_out, d2_match, d2_irq, d2_busy;

   always #5 clk = ~clk;

   pattern_scan_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .bit_valid(bit_valid),
      .bit_out(bit_out), .match(match), .match_count(match_count),
      .irq(irq), .irq_clr(irq_clr), .busy(busy));

   pattern_scan_ctrl #(.DATA_W(8), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .cfg_we(d2_cfg_we), .cfg_pattern(d2_cfg_pattern),
      .cfg_len(d2_cfg_len), .cfg_thresh(d2_cfg_thresh), .in_valid(d2_in_valid),
      .in_ready(d2_in_ready), .in_data(d2_in_data), .bit_valid(d2_bit_valid),
      .bit_out(d2_bit_out), .match(d2_match), .match_count(d2_match_count),
      .irq(d2_irq), .irq_clr(d2_irq_clr), .busy(d2_busy));

   int checks = 0;
   int errors = 0;

   // Behavioural model: the stream seen so far and the detector configuration.
   int m_hist, m_fill, m_pat, m_len, m_thr, m_cnt, m_irq;
   int m_max = (1 << CNT_W) - 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hist = 0; m_fill = 0; m_pat = 8'b0000_1101; m_len = 4; m_thr = 1;
      m_cnt = 0; m_irq = 0;
   endtask

   task automatic model_bit(input int b, output int hit);
      int modulus;
      m_hist  = ((m_hist * 2) + b) % 256;
      m_fill  = (m_fill < 8) ? m_fill + 1 : 8;
      modulus = 1 << m_len;
      hit = (m_fill >= m_len) && ((m_hist % modulus) == (m_pat % modulus));
      if (hit && m_cnt < m_max) begin
         m_cnt++;
         if (m_thr != 0 && m_cnt == m_thr) m_irq = 1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_bit_valid"}, bit_valid, 0);
      check({tag, "_bit_out"}, bit_out, 0);
      check({tag, "_match"}, match, 0);
      check({tag, "_count"}, match_count, 0);
      check({tag, "_irq"}, irq, 0);
   endtask

   task automatic cfg_write(input int pat, input int len, input int thr);
      cfg_we = 1'b1; cfg_pattern = 8'(pat); cfg_len = 4'(len); cfg_thresh = CNT_W'(thr);
      @(negedge clk);
      cfg_we = 1'b0;
      m_pat = pat % 256;
      m_len = (len == 0) ? 1 : ((len > 8) ? 8 : len);
      m_thr = thr; m_hist = 0; m_fill = 0; m_cnt = 0; m_irq = 0;
      check("cfg_count_clr", match_count, 0);
      check("cfg_irq_clr", irq, 0);
   endtask

   task automatic clear_irq();
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      m_irq = 0;
      check("irq_clr", irq, 0);
   endtask

   // Feeds one word from IDLE and checks every cycle until the last match slot.
   task automatic send_word(input logic [7:0] w, input bit cfg_in_shift);
      int exp_m [DATA_W];
      int exp_c [DATA_W];
      int exp_i [DATA_W];
      int prev_c, prev_i, b;
      prev_c = m_cnt; prev_i = m_irq;
      for (int k = 0; k < DATA_W; k++) begin
         b = int'(w[DATA_W-1-k]);
         model_bit(b, exp_m[k]);
         exp_c[k] = m_cnt; exp_i[k] = m_irq;
      end
      check("ready_before", in_ready, 1);
      in_valid = 1'b1; in_data = w;
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_T0", busy, 1);
      check("ready_T0", in_ready, 0);
      for (int c = 1; c <= DATA_W + 1; c++) begin
         if (cfg_in_shift && c == 1) begin
            cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd8; cfg_thresh = '0;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
         if (c <= DATA_W) begin
            check("bit_valid", bit_valid, 1);
            check("bit_out", bit_out, 32'(w[DATA_W-c]));
         end else begin
            check("bit_valid_end", bit_valid, 0);
         end
         if (c >= 2) begin
            check("match", match, exp_m[c-2]);
            check("count", match_count, exp_c[c-2]);
            check("irq", irq, exp_i[c-2]);
         end else begin
            check("match_first", match, 0);
            check("count_first", match_count, prev_c);
            check("irq_first", irq, prev_i);
         end
      end
      cfg_we = 1'b0;
      check("ready_after", in_ready, 1);
   endtask

   initial begin
      rst = 1'b1; cfg_we = 0; in_valid = 0; irq_clr = 0;
      cfg_pattern = 0; cfg_len = 0; cfg_thresh = 0; in_data = 0;
      d2_cfg_we = 0; d2_in_valid = 0; d2_irq_clr = 0;
      d2_cfg_pattern = 0; d2_cfg_len = 0; d2_cfg_thresh = 0; d2_in_data = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Default pattern 1101: single match, irq at threshold 1.
      send_word(8'hD0, 1'b0);
      check("d0_count", match_count, 1);
      check("d0_irq", irq, 1);

      // Overlapping matches.
      cfg_write(8'b0000_1101, 4, 1);
      send_word(8'hDB, 1'b0);
      check("db_count", match_count, 2);

      // Pattern straddling a word boundary.
      cfg_write(8'b0000_1101, 4, 1);
      send_word(8'h01, 1'b0);
      check("straddle_first", match_count, 0);
      send_word(8'hA0, 1'b0);
      check("straddle_second", match_count, 1);

      // Full-length pattern, threshold 2, then an ignored write during SHIFT.
      cfg_write(8'hA5, 8, 2);
      send_word(8'hA5, 1'b0);
      send_word(8'hA5, 1'b0);
      check("a5_count", match_count, 2);
      check("a5_irq", irq, 1);
      send_word(8'hA5, 1'b1);
      check("shift_cfg_ignored", match_count, 3);

      // Length 0 behaves as length 1.
      cfg_write(8'h01, 0, 0);
      send_word(8'h5A, 1'b0);
      check("len0_count", match_count, 4);
      check("len0_irq", irq, 0);

      // Saturation with a 2-bit counter and irq_clr collision.
      d2_cfg_we = 1'b1; d2_cfg_pattern = 8'h01; d2_cfg_len = 4'd1; d2_cfg_thresh = 2'd3;
      @(negedge clk);
      d2_cfg_we = 1'b0;
      d2_in_valid = 1'b1; d2_in_data = 8'hFF;
      @(negedge clk);
      d2_in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("sat_count1", d2_match_count, 1);
      @(negedge clk);
      check("sat_count2", d2_match_count, 2);
      check("sat_irq_pre", d2_irq, 0);
      d2_irq_clr = 1'b1;
      @(negedge clk);
      check("sat_count3", d2_match_count, 3);
      check("sat_irq_set_wins", d2_irq, 1);
      @(negedge clk);
      check("sat_irq_cleared", d2_irq, 0);
      d2_irq_clr = 1'b0;
      repeat (5) @(negedge clk);
      check("sat_count_stuck", d2_match_count, 3);
      check("sat_irq_stays_clr", d2_irq, 0);
      check("sat_ready", d2_in_ready, 1);

      // Reset in the middle of a word.
      cfg_write(8'hA5, 8, 0);
      in_valid = 1'b1; in_data = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_outputs("post_rst");
      send_word(8'hD0, 1'b0);
      check("post_rst_count", match_count, 1);

      // Random words and configurations against the model.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(3) == 0)
            cfg_write(int'($urandom_range(255)), int'($urandom_range(15)), int'($urandom_range(6)));
         if ($urandom_range(4) == 0)
            clear_irq();
         send_word(8'($urandom_range(255)), bit'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
